// File: rtl/hax_serial_pkg.sv
// hax_serial_pkg: state encodings and width legality for the bit-serial adder sequencer
package hax_serial_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam int MIN_WIDTH = 1;
   localparam int MAX_WIDTH = 64;
   function automatic bit width_ok(input int w);
      return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
   endfunction
endpackage

// File: rtl/hax_fa_slice.sv
// hax_fa_slice: one full-adder bit built from two half adders and an OR
module hax_fa_slice (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic S,
   output logic CO
);
   logic p, g1, g2;
   assign p  = A ^ B;
   assign g1 = A & B;
   assign S  = p ^ CI;
   assign g2 = p & CI;
   assign CO = g1 | g2;
endmodule

// File: rtl/hax_serial_adder_ctrl.sv
// hax_serial_adder_ctrl: adds WIDTH-bit operands LSB-first through a single shared full-adder slice
module hax_serial_adder_ctrl
   import hax_serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT,
   output logic             BUSY
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("hax_serial_adder_ctrl: WIDTH out of range 1..64");
   end
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             carry, s, co, cout_q;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt, sum_q;
   hax_fa_slice u_fa (.A(a_sh[0]), .B(b_sh[0]), .CI(carry), .S(s), .CO(co));
   assign s_nxt = WIDTH'({s, s_sh} >> 1);
   // result kept in its own register so SUM/COUT hold the last answer while the next op shifts
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         carry  <= 1'b0;
         a_sh   <= '0;
         b_sh   <= '0;
         s_sh   <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (IN_VALID) begin
               a_sh  <= A;
               b_sh  <= B;
               carry <= CIN;
               cnt   <= '0;
               state <= ST_RUN;
            end
            ST_RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               s_sh  <= s_nxt;
               carry <= co;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  cnt    <= '0;
                  state  <= ST_DONE;
                  sum_q  <= s_nxt;
                  cout_q <= co;
               end else cnt <= cnt + CNT_W'(1);
            end
            ST_DONE: if (OUT_READY) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
   assign IN_READY  = (state == ST_IDLE);
   assign OUT_VALID = (state == ST_DONE);
   assign BUSY      = (state == ST_RUN) || (state == ST_DONE);
   assign SUM       = sum_q;
   assign COUT      = cout_q;
endmodule

// File: tb/tb_hax_serial_adder_ctrl.sv
// tb_hax_serial_adder_ctrl: directed and random checks of the bit-serial adder at WIDTH=8 and WIDTH=1
module tb_hax_serial_adder_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       in_ready, out_valid, cout, busy;
   logic [7:0] sum;
   logic       in_valid1 = 1'b0, out_ready1 = 1'b1, cin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0, sum1;
   logic       in_ready1, out_valid1, cout1, busy1;
   int         vecs = 0, errs = 0, lat;
   bit         saw_valid;
   logic [8:0] ref_t;
   always #5 clk = ~clk;
   hax_serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a), .B(b), .CIN(cin),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .SUM(sum), .COUT(cout), .BUSY(busy)
   );
   hax_serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid1), .IN_READY(in_ready1), .A(a1), .B(b1), .CIN(cin1),
      .OUT_VALID(out_valid1), .OUT_READY(out_ready1), .SUM(sum1), .COUT(cout1), .BUSY(busy1)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_done8();
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask
   // accept one op on dut8 and stop in DONE with the result checked
   task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                         input logic [7:0] es, input logic ec);
      chk("ready_before_op", in_ready, 1);
      a = xa; b = xb; cin = xc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("busy_after_accept", {in_ready, busy}, 2'b01);
      wait_done8();
      chk("latency", lat, 8);
      chk("sum", sum, es);
      chk("cout", cout, ec);
   endtask
   task automatic release_op();
      out_ready = 1'b1;
      tick();
      chk("idle_after_release", {in_ready, out_valid, busy}, 3'b100);
   endtask
   initial begin
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_w1_outputs", {in_ready1, out_valid1, busy1, sum1, cout1}, 5'b10000);
      rst = 1'b0;
      tick();
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      release_op();
      run_op(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);
      release_op();
      out_ready = 1'b0;
      run_op(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", {out_valid, in_ready, busy, cout, sum}, {4'b1011, 8'h2C});
      end
      release_op();
      a = 8'h5A; b = 8'h33; cin = 1'b1; in_valid = 1'b1;
      tick();
      a = 8'h01; b = 8'h02; cin = 1'b0;
      wait_done8();
      chk("ovl_latency", lat, 8);
      chk("ovl_first_result", {cout, sum}, 9'h08E);
      tick();
      chk("ovl_idle_again", {in_ready, busy}, 2'b10);
      tick();
      in_valid = 1'b0;
      chk("ovl_second_accept", {in_ready, busy}, 2'b01);
      wait_done8();
      chk("ovl_second_latency", lat, 8);
      chk("ovl_second_result", {cout, sum}, 9'h003);
      tick();
      a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrun_rst_state", {in_ready, out_valid, busy}, 3'b100);
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         saw_valid |= out_valid;
      end
      chk("midrun_rst_no_valid", saw_valid, 0);
      run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
      release_op();
      for (int i = 0; i < 4; i++) begin
         logic [2:0] v;
         v = (i == 0) ? 3'b111 : (i == 1) ? 3'b010 : (i == 2) ? 3'b101 : 3'b000;
         a1 = v[2]; b1 = v[1]; cin1 = v[0]; in_valid1 = 1'b1;
         tick();
         in_valid1 = 1'b0;
         lat = 0;
         while (!out_valid1 && lat < 10) begin
            tick();
            lat++;
         end
         chk("w1_latency", lat, 1);
         chk("w1_result", {cout1, sum1}, 2'(v[2] + v[1] + v[0]));
         tick();
         chk("w1_idle", {in_ready1, busy1}, 2'b10);
      end
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         ref_t = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         run_op(ra, rb, rc, ref_t[7:0], ref_t[8]);
         release_op();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
